// File: rtl/ddr_seq_pkg.sv
// Shared types and helpers for the DDR output sequencer.
package ddr_seq_pkg;

  // Sequencer phases around a burst on the pad.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    POST  = 2'd3
  } state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ddr_shift2.sv
// Word register that hands out two bits per beat, MSB pair first.
// r_cnt counts beats already taken from the register, so the beat on the
// pad is the final one of its word when r_cnt equals WIDTH/2.
module ddr_shift2
  import ddr_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,     // capture i_data
  input  logic             i_present,  // with i_load: first pair is being sent now
  input  logic             i_shift,    // current head pair is being sent now
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head_hi,  // next pair to send, bit for rising edge
  output logic             o_head_lo,  // next pair to send, bit for falling edge
  output logic             o_final     // last pair of the word is on the pad
);

  localparam int BEATS = WIDTH / 2;
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;

  // Load a fresh word (optionally consuming its first pair) or shift by one pair.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      if (i_present) begin
        r_sr  <= i_data << 2;
        r_cnt <= CW'(1);
      end else begin
        r_sr  <= i_data;
        r_cnt <= '0;
      end
    end else if (i_shift) begin
      r_sr  <= r_sr << 2;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_head_hi = r_sr[WIDTH-1];
  assign o_head_lo = r_sr[WIDTH-2];
  assign o_final   = (r_cnt == BEATS_C);

endmodule

// File: rtl/ddr_oddr_sequencer.sv
// Serializes parallel words into two bits per clock for an FDDR+OBUFT pad
// cell, wrapping each burst with a driven preamble and postamble. Every pad
// output is registered from the next-state decode so the cell sees clean
// flop outputs; only IN_READY is combinational.
module ddr_oddr_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   PRE_CYCLES  = 1,
  parameter int   POST_CYCLES = 1,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic             D0,
  output logic             D1,
  output logic             CE,
  output logic             T,
  output logic             BUSY,
  output logic             UNDERRUN
);

  localparam int PH_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int PCW    = cnt_width(PH_MAX);
  localparam logic [PCW-1:0] PRE_LAST  = (PRE_CYCLES  == 0) ? '0 : PCW'(PRE_CYCLES - 1);
  localparam logic [PCW-1:0] POST_LAST = (POST_CYCLES == 0) ? '0 : PCW'(POST_CYCLES - 1);

  state_t         r_state, w_state_next;
  logic [PCW-1:0] r_phase, w_phase_next;
  logic           r_last, w_last_next;
  logic           r_d0, r_d1, r_ce, r_t, r_busy, r_under;
  logic           w_d0_next, w_d1_next, w_ce_next, w_t_next, w_under_next;
  logic           w_load, w_present, w_shift;
  logic           w_head_hi, w_head_lo, w_final;
  logic           w_ready, w_accept;

  ddr_shift2 #(
    .WIDTH(WIDTH)
  ) u_shift (
    .i_clk     (C),
    .i_rst_n   (CLR_N),
    .i_load    (w_load),
    .i_present (w_present),
    .i_shift   (w_shift),
    .i_data    (IN_DATA),
    .o_head_hi (w_head_hi),
    .o_head_lo (w_head_lo),
    .o_final   (w_final)
  );

  // Ready in IDLE, and on the final beat (or gap beats) of a non-last word.
  assign w_ready  = CLR_N && ((r_state == IDLE) ||
                              ((r_state == SHIFT) && w_final && !r_last));
  assign w_accept = IN_VALID && w_ready;
  assign IN_READY = w_ready;

  // Next-state decode; pad outputs are computed for the state being entered.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_last_next  = r_last;
    w_d0_next    = IDLE_VAL;
    w_d1_next    = IDLE_VAL;
    w_ce_next    = 1'b1;
    w_t_next     = 1'b0;
    w_under_next = 1'b0;
    w_load       = 1'b0;
    w_present    = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ce_next = 1'b0;
        w_t_next  = 1'b1;
        if (w_accept) begin
          w_load      = 1'b1;
          w_last_next = IN_LAST;
          w_ce_next   = 1'b1;
          w_t_next    = 1'b0;
          if (PRE_CYCLES == 0) begin
            w_present    = 1'b1;
            w_d0_next    = IN_DATA[WIDTH-1];
            w_d1_next    = IN_DATA[WIDTH-2];
            w_state_next = SHIFT;
          end else begin
            w_phase_next = '0;
            w_state_next = PRE;
          end
        end
      end
      PRE: begin
        if (r_phase == PRE_LAST) begin
          w_shift      = 1'b1;
          w_d0_next    = w_head_hi;
          w_d1_next    = w_head_lo;
          w_state_next = SHIFT;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      SHIFT: begin
        if (!w_final) begin
          w_shift   = 1'b1;
          w_d0_next = w_head_hi;
          w_d1_next = w_head_lo;
        end else if (r_last) begin
          if (POST_CYCLES == 0) begin
            w_ce_next    = 1'b0;
            w_t_next     = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_phase_next = '0;
            w_state_next = POST;
          end
        end else if (w_accept) begin
          // Back-to-back word: its first pair goes out with no gap.
          w_load      = 1'b1;
          w_present   = 1'b1;
          w_last_next = IN_LAST;
          w_d0_next   = IN_DATA[WIDTH-1];
          w_d1_next   = IN_DATA[WIDTH-2];
        end else begin
          // Source ran dry mid-burst: keep the pad driven with a gap beat.
          w_under_next = 1'b1;
        end
      end
      POST: begin
        if (r_phase == POST_LAST) begin
          w_ce_next    = 1'b0;
          w_t_next     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      default: begin
        w_ce_next    = 1'b0;
        w_t_next     = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered pad outputs; reset tristates the pad at once.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_last  <= 1'b0;
      r_d0    <= IDLE_VAL;
      r_d1    <= IDLE_VAL;
      r_ce    <= 1'b0;
      r_t     <= 1'b1;
      r_busy  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_last  <= w_last_next;
      r_d0    <= w_d0_next;
      r_d1    <= w_d1_next;
      r_ce    <= w_ce_next;
      r_t     <= w_t_next;
      r_busy  <= (w_state_next != IDLE);
      r_under <= w_under_next;
    end
  end

  assign D0       = r_d0;
  assign D1       = r_d1;
  assign CE       = r_ce;
  assign T        = r_t;
  assign BUSY     = r_busy;
  assign UNDERRUN = r_under;

endmodule

// File: tb/tb_ddr_oddr_sequencer.sv
// Self-checking bench for ddr_oddr_sequencer: per-cycle vector table, a
// pad-beat scoreboard, and hand sequences for gaps, reset and PRE/POST=0.
module tb_ddr_oddr_sequencer;

  logic       C = 1'b0;
  logic       CLR_N;
  logic [7:0] IN_DATA;
  logic       IN_VALID, IN_LAST;
  logic       IN_READY, D0, D1, CE, T, BUSY, UNDERRUN;

  logic [7:0] z_data;
  logic       z_valid, z_last;
  logic       z_ready, z_d0, z_d1, z_ce, z_t, z_busy, z_und;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  logic [2:0] sb[$];  // expected pad beats {D0, D1, UNDERRUN}

  always #5 C = ~C;

  ddr_oddr_sequencer #(.WIDTH(8), .PRE_CYCLES(1), .POST_CYCLES(1), .IDLE_VAL(1'b1)) dut (
    .C(C), .CLR_N(CLR_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .D0(D0), .D1(D1), .CE(CE), .T(T), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  ddr_oddr_sequencer #(.WIDTH(8), .PRE_CYCLES(0), .POST_CYCLES(0), .IDLE_VAL(1'b1)) dut0 (
    .C(C), .CLR_N(CLR_N), .IN_DATA(z_data), .IN_VALID(z_valid), .IN_LAST(z_last),
    .IN_READY(z_ready), .D0(z_d0), .D1(z_d1), .CE(z_ce), .T(z_t), .BUSY(z_busy), .UNDERRUN(z_und)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int b = 3; b >= 0; b--) sb.push_back({w[2*b+1], w[2*b], 1'b0});
  endtask

  task automatic push_idle(input int n, input logic u);
    for (int k = 0; k < n; k++) sb.push_back({1'b1, 1'b1, u});
  endtask

  // Every driven pad cycle must match the next expected beat.
  always @(negedge C) begin
    if (mon_en && CLR_N && !T) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra_beat: got D=%b%b U=%b with nothing expected", D0, D1, UNDERRUN);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        chk("sb_beat", 32'({D0, D1, UNDERRUN, CE}), 32'({e, 1'b1}));
      end
    end
  end

  // Present one word starting at a negedge; withhold it for `gap` ready cycles.
  task automatic send(input logic [7:0] w, input logic l, input int gap, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    IN_DATA = w;
    IN_LAST = l;
    for (int g = 0; g < 200; g++) begin
      if (IN_READY && n < gap) begin
        IN_VALID = 1'b0;
        n++;
      end else begin
        IN_VALID = 1'b1;
      end
      if (IN_READY && IN_VALID) begin
        @(negedge C);
        ok = 1;
        break;
      end
      @(negedge C);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 64; k++) begin
      @(negedge C);
      if (!BUSY) break;
    end
    chk(name, 32'(BUSY), 32'd0);
  endtask

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [6:0] exp;  // {IN_READY, BUSY, T, CE, D0, D1, UNDERRUN}
  } vec_t;

  localparam logic [6:0] IDLE_R = 7'b1010110;
  localparam logic [6:0] PAD11  = 7'b0101110;

  function automatic logic [6:0] bt(input logic x, input logic y, input logic r);
    return {r, 1'b1, 1'b0, 1'b1, x, y, 1'b0};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic [6:0] e);
    return {v, d, l, e};
  endfunction

  vec_t vecs[20];

  initial begin
    bit ok;
    logic [1:0] zexp[4];

    vecs[0]  = mk(1, 8'hA5, 1, IDLE_R);
    vecs[1]  = mk(0, 8'h00, 0, PAD11);
    vecs[2]  = mk(0, 8'h00, 0, bt(1, 0, 0));
    vecs[3]  = mk(0, 8'h00, 0, bt(1, 0, 0));
    vecs[4]  = mk(0, 8'h00, 0, bt(0, 1, 0));
    vecs[5]  = mk(0, 8'h00, 0, bt(0, 1, 0));
    vecs[6]  = mk(0, 8'h00, 0, PAD11);
    vecs[7]  = mk(0, 8'h00, 0, IDLE_R);
    vecs[8]  = mk(1, 8'hF0, 0, IDLE_R);
    vecs[9]  = mk(1, 8'h0F, 1, PAD11);
    vecs[10] = mk(1, 8'h0F, 1, bt(1, 1, 0));
    vecs[11] = mk(1, 8'h0F, 1, bt(1, 1, 0));
    vecs[12] = mk(1, 8'h0F, 1, bt(0, 0, 0));
    vecs[13] = mk(1, 8'h0F, 1, bt(0, 0, 1));
    vecs[14] = mk(0, 8'h0F, 1, bt(0, 0, 0));
    vecs[15] = mk(0, 8'h00, 0, bt(0, 0, 0));
    vecs[16] = mk(0, 8'h00, 0, bt(1, 1, 0));
    vecs[17] = mk(0, 8'h00, 0, bt(1, 1, 0));
    vecs[18] = mk(0, 8'h00, 0, PAD11);
    vecs[19] = mk(0, 8'h00, 0, IDLE_R);

    CLR_N = 1'b0;
    IN_DATA = '0; IN_VALID = 1'b0; IN_LAST = 1'b0;
    z_data = '0; z_valid = 1'b0; z_last = 1'b0;
    repeat (2) @(negedge C);
    chk("reset_state", 32'({IN_READY, BUSY, T, CE, D0, D1, UNDERRUN}), 32'(7'b0010110));
    chk("reset_state_z", 32'({z_ready, z_busy, z_t, z_ce, z_d0, z_d1, z_und}), 32'(7'b0010110));
    CLR_N = 1'b1;
    @(negedge C);
    mon_en = 1;

    // Single word A5, then F0/0F back to back with IN_VALID held through PRE.
    push_idle(1, 0); push_word(8'hA5); push_idle(1, 0);
    push_idle(1, 0); push_word(8'hF0); push_word(8'h0F); push_idle(1, 0);
    for (int i = 0; i < 20; i++) begin
      IN_VALID = vecs[i].v;
      IN_DATA  = vecs[i].d;
      IN_LAST  = vecs[i].l;
      chk($sformatf("vec%0d", i), 32'({IN_READY, BUSY, T, CE, D0, D1, UNDERRUN}), 32'(vecs[i].exp));
      @(negedge C);
    end
    IN_VALID = 1'b0;
    repeat (2) @(negedge C);
    chk("sb_drain_table", 32'(sb.size()), 32'd0);

    // Underrun: C3 (not last), two withheld ready cycles, then 5A (last).
    push_idle(1, 0); push_word(8'hC3); push_idle(2, 1); push_word(8'h5A); push_idle(1, 0);
    send(8'hC3, 1'b0, 0, ok);
    chk("gap_accept0", 32'(ok), 32'd1);
    send(8'h5A, 1'b1, 2, ok);
    chk("gap_accept1", 32'(ok), 32'd1);
    IN_VALID = 1'b0;
    wait_idle("gap_idle");
    repeat (2) @(negedge C);
    chk("sb_drain_gap", 32'(sb.size()), 32'd0);

    // Reset during the second data beat; no postamble afterwards.
    mon_en = 0;
    send(8'hA5, 1'b1, 0, ok);
    IN_VALID = 1'b0;
    chk("rst_accept", 32'(ok), 32'd1);
    repeat (2) @(negedge C);
    chk("rst_before", 32'({T, D0, D1}), 32'(3'b010));
    CLR_N = 1'b0;
    #1;
    chk("rst_async", 32'({IN_READY, BUSY, T, CE, D0, D1, UNDERRUN}), 32'(7'b0010110));
    repeat (2) @(negedge C);
    CLR_N = 1'b1;
    @(negedge C);
    chk("rst_release", 32'({IN_READY, T, CE, BUSY}), 32'(4'b1100));
    sb.delete();
    mon_en = 1;
    push_idle(1, 0); push_word(8'hA5); push_idle(1, 0);
    send(8'hA5, 1'b1, 0, ok);
    IN_VALID = 1'b0;
    chk("post_rst_pre", 32'({T, CE, D0, D1}), 32'(4'b0111));
    @(negedge C);
    chk("post_rst_beat0", 32'({T, D0, D1}), 32'(3'b010));
    wait_idle("post_rst_idle");
    repeat (2) @(negedge C);
    chk("sb_drain_rst", 32'(sb.size()), 32'd0);

    // PRE=0 / POST=0 instance: first beat right after accept, T=1 right after last.
    zexp[0] = 2'b10; zexp[1] = 2'b01; zexp[2] = 2'b01; zexp[3] = 2'b10;
    z_valid = 1'b1; z_data = 8'h96; z_last = 1'b1;
    chk("z_ready_idle", 32'(z_ready), 32'd1);
    @(negedge C);
    z_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("z_beat%0d", k), 32'({z_t, z_ce, z_d0, z_d1, z_und}), 32'({2'b01, zexp[k], 1'b0}));
      @(negedge C);
    end
    chk("z_end", 32'({z_t, z_ce, z_busy, z_ready}), 32'(4'b1001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_oddr_sequencer.md
Name: ddr_oddr_sequencer

Overview:
Converts a stream of parallel words into 2-bit-per-clock beats for an external DDR tristate output cell (FDDR flop with OBUFT). It drives that cell's D0, D1, CE and T pins, sequences output-enable preamble and postamble around each burst, and accepts words over a valid/ready handshake. It sits between a packet source (for example the PicoBlaze port logic) and the pad-level DDR output primitive.

Parameters:
WIDTH, 8, input word width in bits; must be even and at least 2
PRE_CYCLES, 1, cycles of driven IDLE_VAL with T=0 before the first data beat; range 0..15
POST_CYCLES, 1, cycles of driven IDLE_VAL after the last data beat before T returns to 1; range 0..15
IDLE_VAL, 1'b1, bit value driven on D0 and D1 during preamble, postamble and underrun beats

Ports:
C  in  1  single system clock; DDR cell uses C (C0) and its inverse (C1)
CLR_N  in  1  asynchronous active-low reset
IN_DATA  in  WIDTH  word to serialize, MSB first
IN_VALID  in  1  IN_DATA and IN_LAST are valid
IN_LAST  in  1  current word ends the burst
IN_READY  out  1  word accepted when IN_VALID && IN_READY at rising C
D0  out  1  to DDR cell D0, bit launched on rising C
D1  out  1  to DDR cell D1, bit launched on falling C
CE  out  1  to DDR cell CE
T  out  1  to DDR cell T; 1 = pad tristated
BUSY  out  1  high in any state other than IDLE
UNDERRUN  out  1  one-cycle pulse for each inserted gap beat

Behaviour:
- Reset (CLR_N=0, async): state=IDLE, D0=D1=IDLE_VAL, CE=0, T=1, BUSY=0, UNDERRUN=0, shift register and counters cleared. IN_READY=0 while CLR_N=0.
- All outputs except IN_READY are registered. IN_READY is combinational from state and counters.
- FSM states are IDLE, PRE, SHIFT, POST.
- IDLE: T=1, CE=0, IN_READY=1. On accept, load the shift register, latch IN_LAST, and go to PRE. If PRE_CYCLES=0, go directly to SHIFT.
- PRE: T=0, CE=1, D0=D1=IDLE_VAL for exactly PRE_CYCLES cycles, then SHIFT.
- SHIFT: each cycle drives D0=sr[WIDTH-1] and D1=sr[WIDTH-2], then shifts left by 2. A beat counter runs 0..WIDTH/2-1.
  - IN_READY=1 only on the final beat of a word whose latched last flag is 0.
  - Final beat with last=1: go to POST (or IDLE if POST_CYCLES=0).
  - Final beat with last=0 and a word accepted: load the new word; its first beat follows with no gap.
  - Final beat with last=0 and no word available: insert gap beats (D0=D1=IDLE_VAL, T=0, UNDERRUN=1 per beat). Keep IN_READY=1 during gap beats until a word is accepted; the next cycle is that word's first beat.
- POST: T=0, CE=1, D0=D1=IDLE_VAL for POST_CYCLES cycles, then IDLE with T=1 and CE=0.
- Latency: accept in IDLE at cycle t; first data beat on D0/D1 at t+1+PRE_CYCLES. Total pad-driven cycles for a single-word burst = PRE_CYCLES + WIDTH/2 + POST_CYCLES.
- IN_LAST is sampled only on accept. IN_VALID outside IN_READY windows is ignored (no accept).
- Reset mid-burst returns T=1 immediately (async). The partial word is discarded and there is no postamble.
- Counters are sized to clog2 of their maximum; no wrap-around occurs inside a state.

Decomposition:
- Shared package (ddr_seq_pkg): state enum (IDLE, PRE, SHIFT, POST) and the counter-width constant function.
- One sub-module, ddr_shift2: a WIDTH-bit load/shift-by-2 register with beat counter and final_beat flag. The FSM stays in the top level.

Test Plan:
- WIDTH=8, PRE=1, POST=1; single word 8'hA5 with last=1 accepted at cycle 0:
  - cycle 1: T=0, D=11 (preamble).
  - cycles 2-5: (D0,D1) = 10,10,01,01.
  - cycle 6: postamble 11.
  - cycle 7: T=1, CE=0, BUSY=0.
- Two words 8'hF0 (last=0) and 8'h0F (last=1), IN_VALID held high: 8 contiguous data beats 11,11,00,00,00,00,11,11; IN_READY high only on the 4th beat; no UNDERRUN.
- Word 8'hC3 with last=0, then IN_VALID low for 2 cycles:
  - two gap beats at 11 with UNDERRUN=1 and T=0.
  - the next word starts on the cycle after its accept.
- Reset asserted on the 2nd data beat: T=1, CE=0, D=11 immediately. After release, IN_READY=1 and a new burst behaves as in the first scenario.
- PRE=0, POST=0: accept at t gives the first beat at t+1. T=1 on the cycle after the final beat.
- IN_VALID held high continuously during mid-word SHIFT beats: IN_READY=0 and no accept until the final beat; the word is then accepted exactly once.
